// File: rtl/hba_arbiter_pkg.sv
// Shared HBA bus widths and arbiter state encoding.
package hba_arbiter_pkg;

  localparam int ABUS  = 12;
  localparam int DBUS  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hba_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_MASTERS.
module hba_arbiter_rr_pick
  import hba_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic                   any,
  output logic [IDX_W-1:0]       win_idx
);

  // Scan from farthest to nearest so the nearest requester after 'last' overwrites the rest.
  always_comb begin
    any     = |req;
    win_idx = last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_MASTERS]) begin
        win_idx = IDX_W'((int'(last) + k) % NUM_MASTERS);
      end else begin
        win_idx = win_idx;
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// HBA bus arbiter: round-robin grant FSM with optional transfer watchdog.
// Optional feature macro: HBA_ARB_TIMEOUT_EN (timeout ack, sticky error and id).
module hba_arbiter
  import hba_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_MASTERS-1:0] master_request,
  input  logic                   hba_select,
  input  logic                   hba_xferack,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic                   arb_busy,
  output logic                   arb_xferack,
  output logic                   timeout_err,
  output logic [2:0]             timeout_id,
  input  logic                   timeout_clr
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   pick_any;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_req;

  hba_arbiter_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req     (master_request),
    .last    (last_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (last_q == IDX_W'(i)) begin
        owner_req = master_request[i];
      end else begin
        owner_req = owner_req;
      end
    end
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = GRANT;
        else          state_d = IDLE;
      end
      GRANT: begin
        if (owner_req) state_d = GRANT;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant and winner registers; leaving GRANT always passes through an empty IDLE cycle.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          last_d = pick_idx;
          for (int i = 0; i < NUM_MASTERS; i++) grant_d[i] = (pick_idx == IDX_W'(i));
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (owner_req) grant_d = grant_q;
        else           grant_d = '0;
      end
      default: grant_d = '0;
    endcase
  end

  assign hba_mgrant = grant_q;
  assign arb_busy   = (state_q == GRANT);

`ifdef HBA_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        xack_q, xack_d;
  logic        err_q, err_d;
  logic [2:0]  id_q, id_d;
  logic        stall;
  logic        fire;

  always_comb begin
    stall  = (state_q == GRANT) && hba_select && !hba_xferack;
    fire   = stall && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    xack_d = fire;
    id_d   = id_q;
    if (fire) begin
      cnt_d = 16'd0;
      id_d  = last_q;
    end else if (stall) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end
    // A timeout in the same cycle as a clear request keeps the error set.
    if (fire)             err_d = 1'b1;
    else if (timeout_clr) err_d = 1'b0;
    else                  err_d = err_q;
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      cnt_q  <= 16'd0;
      xack_q <= 1'b0;
      err_q  <= 1'b0;
      id_q   <= 3'd0;
    end else begin
      cnt_q  <= cnt_d;
      xack_q <= xack_d;
      err_q  <= err_d;
      id_q   <= id_d;
    end
  end

  assign arb_xferack = xack_q;
  assign timeout_err = err_q;
  assign timeout_id  = id_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{hba_select, hba_xferack, timeout_clr, 16'(TIMEOUT_CYCLES)};
  assign arb_xferack   = 1'b0;
  assign timeout_err   = 1'b0;
  assign timeout_id    = 3'd0;
`endif

endmodule
